// File: rtl/worksheet_pkg.sv
// Shared constants, line/op codes and state enum for the worksheet loader and compactor.
package worksheet_pkg;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned MAX_COLS   = 1000;
    localparam int unsigned LINE_W     = 3;

    localparam logic [LINE_W-1:0] LINE_OP = 3'd4;
    localparam logic              OP_MUL  = 1'b0;
    localparam logic              OP_ADD  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NUM,
        S_OPS,
        S_DONE,
        S_ERR
    } state_e;
endpackage

// File: rtl/ascii_num_acc.sv
// Decimal digit accumulator: value = value*10 + digit, with overflow flag for the pending digit.
module ascii_num_acc #(
    parameter int unsigned DATA_WIDTH = worksheet_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  dig_en,
    input  logic [3:0]            digit,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  ovf_c
);
    localparam int unsigned EXT_W = DATA_WIDTH + 4;

    logic [EXT_W-1:0] next_c;

    // Four extra bits hold value*10+9 without wrapping.
    assign next_c = (EXT_W'(value) * EXT_W'(10)) + EXT_W'(digit);
    assign ovf_c  = dig_en && (next_c[EXT_W-1:DATA_WIDTH] != '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (dig_en && !ovf_c) begin
            value <= next_c[DATA_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/worksheet_loader.sv
// Parses an ASCII worksheet (four number lines plus an op line) into column-memory writes.
// Define LOADER_CHECKSUM_EN to keep a running 64-bit sum of number-line writes.
module worksheet_loader #(
    parameter int unsigned DATA_WIDTH = worksheet_pkg::DATA_WIDTH,
    parameter int unsigned MAX_COLS   = worksheet_pkg::MAX_COLS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    input  logic                        in_last,
    output logic                        wr_en,
    output logic [2:0]                  wr_line,
    output logic [$clog2(MAX_COLS)-1:0] wr_col,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        done,
    output logic                        error,
    output logic [$clog2(MAX_COLS):0]   num_cols,
    output logic [63:0]                 checksum
);
    import worksheet_pkg::LINE_OP;
    import worksheet_pkg::OP_MUL;
    import worksheet_pkg::OP_ADD;
    import worksheet_pkg::state_e;
    import worksheet_pkg::S_IDLE;
    import worksheet_pkg::S_NUM;
    import worksheet_pkg::S_OPS;
    import worksheet_pkg::S_DONE;
    import worksheet_pkg::S_ERR;

    localparam int unsigned COL_W  = $clog2(MAX_COLS);
    localparam int unsigned NCOL_W = COL_W + 1;

    state_e                  state_q, state_nx;
    logic [2:0]              line_q, line_nx;
    logic [NCOL_W-1:0]       col_q, col_nx, col_inc, end_cols, num_cols_nx;
    logic                    have_tok_q, have_tok_nx;
    logic                    wr_en_nx;
    logic [2:0]              wr_line_nx;
    logic [COL_W-1:0]        wr_col_nx;
    logic [DATA_WIDTH-1:0]   wr_data_nx;
    logic                    done_nx, error_nx, in_ready_nx;
    logic                    clear_all, acc_clr, acc_dig, acc_ovf_c, fault, wr_req, line_end;
    logic [DATA_WIDTH-1:0]   acc_value;
    logic                    xfer, is_digit, is_sp, is_nl, is_cr, is_mul, is_add, is_op, col_full;

    assign xfer     = in_valid && in_ready;
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_sp    = (in_data == 8'h20);
    assign is_nl    = (in_data == 8'h0A);
    assign is_cr    = (in_data == 8'h0D);
    assign is_mul   = (in_data == 8'h2A);
    assign is_add   = (in_data == 8'h2B);
    assign is_op    = is_mul || is_add;
    assign col_inc  = col_q + NCOL_W'(1);
    assign col_full = (col_q >= NCOL_W'(MAX_COLS));

    ascii_num_acc #(.DATA_WIDTH(DATA_WIDTH)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .dig_en (acc_dig),
        .digit  (in_data[3:0]),
        .value  (acc_value),
        .ovf_c  (acc_ovf_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state and next-output decode; a fault on a byte suppresses its write.
    always_comb begin
        state_nx    = state_q;
        line_nx     = line_q;
        col_nx      = col_q;
        num_cols_nx = num_cols;
        have_tok_nx = have_tok_q;
        wr_line_nx  = wr_line;
        wr_col_nx   = wr_col;
        wr_data_nx  = wr_data;
        done_nx     = done;
        error_nx    = error;
        clear_all   = 1'b0;
        acc_clr     = 1'b0;
        acc_dig     = 1'b0;
        fault       = 1'b0;
        wr_req      = 1'b0;
        line_end    = 1'b0;
        end_cols    = col_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    clear_all = 1'b1;
                    state_nx  = S_NUM;
                end
            end
            S_NUM: begin
                if (xfer) begin
                    end_cols = have_tok_q ? col_inc : col_q;
                    if (in_last) begin
                        fault = 1'b1;
                    end else if (is_digit) begin
                        acc_dig     = 1'b1;
                        have_tok_nx = 1'b1;
                        fault       = acc_ovf_c;
                    end else if (is_sp || is_nl) begin
                        wr_req      = have_tok_q;
                        acc_clr     = 1'b1;
                        have_tok_nx = 1'b0;
                        line_end    = is_nl && (end_cols != '0);
                        if (have_tok_q && col_full) fault = 1'b1;
                        if (line_end && (line_q != '0) && (end_cols != num_cols)) fault = 1'b1;
                        col_nx = line_end ? '0 : end_cols;
                        if (line_end) begin
                            line_nx = line_q + 3'd1;
                            if (line_q == '0) num_cols_nx = end_cols;
                            if (line_q == 3'd3) state_nx = S_OPS;
                        end
                    end else if (!is_cr) begin
                        fault = 1'b1;
                    end
                    if (wr_req) begin
                        wr_line_nx = line_q;
                        wr_col_nx  = col_q[COL_W-1:0];
                        wr_data_nx = acc_value;
                    end
                end
            end
            S_OPS: begin
                if (xfer) begin
                    end_cols = is_op ? col_inc : col_q;
                    if (!(is_op || is_sp || is_nl || is_cr)) begin
                        fault = 1'b1;
                    end else begin
                        wr_req = is_op;
                        if (is_op && col_full) fault = 1'b1;
                        if (is_nl || in_last) begin
                            if (end_cols == '0) begin
                                fault = in_last;
                            end else if (end_cols != num_cols) begin
                                fault = 1'b1;
                            end else begin
                                state_nx = S_DONE;
                                done_nx  = 1'b1;
                            end
                        end
                        if (is_op) col_nx = col_inc;
                    end
                    if (wr_req) begin
                        wr_line_nx = LINE_OP;
                        wr_col_nx  = col_q[COL_W-1:0];
                        wr_data_nx = DATA_WIDTH'(is_add ? OP_ADD : OP_MUL);
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (fault) begin
            state_nx = S_ERR;
            error_nx = 1'b1;
            done_nx  = 1'b0;
            wr_req   = 1'b0;
        end

        if (clear_all) begin
            line_nx     = '0;
            col_nx      = '0;
            num_cols_nx = '0;
            have_tok_nx = 1'b0;
            done_nx     = 1'b0;
            error_nx    = 1'b0;
            acc_clr     = 1'b1;
        end

        wr_en_nx    = wr_req;
        in_ready_nx = (state_nx != S_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q     <= '0;
            col_q      <= '0;
            have_tok_q <= 1'b0;
            num_cols   <= '0;
            wr_en      <= 1'b0;
            wr_line    <= '0;
            wr_col     <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            line_q     <= line_nx;
            col_q      <= col_nx;
            have_tok_q <= have_tok_nx;
            num_cols   <= num_cols_nx;
            wr_en      <= wr_en_nx;
            wr_line    <= wr_line_nx;
            wr_col     <= wr_col_nx;
            wr_data    <= wr_data_nx;
            done       <= done_nx;
            error      <= error_nx;
            in_ready   <= in_ready_nx;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Sum lands in the same cycle the write is presented.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            checksum <= '0;
        end else if (wr_en_nx && (wr_line_nx != LINE_OP)) begin
            checksum <= checksum + 64'(wr_data_nx);
        end
    end
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_worksheet_loader.sv
// Randomized self-checking bench for worksheet_loader against a string-level worksheet model.
module tb_worksheet_loader;
    localparam int MAXC = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h0;
    logic        in_last = 1'b0;
    logic        wr_en;
    logic [2:0]  wr_line;
    logic [9:0]  wr_col;
    logic [15:0] wr_data;
    logic        done, error;
    logic [10:0] num_cols;
    logic [63:0] checksum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int byte_cyc[4096];

    logic [28:0] exp_w[$];
    int          exp_i[$];
    logic [28:0] dut_w[$];
    int          dut_c[$];
    bit          exp_done, exp_err;
    int          exp_ncols;
    longint unsigned exp_sum;

    worksheet_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col), .wr_data(wr_data),
        .done(done), .error(error), .num_cols(num_cols), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_en) begin
            dut_w.push_back({wr_line, wr_col, wr_data});
            dut_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int ln, input int cl, input int v, input int idx);
        exp_w.push_back({3'(ln), 10'(cl), 16'(v)});
        exp_i.push_back(idx);
        if (ln < 4) exp_sum += longint'(unsigned'(v));
    endtask

    // Worksheet rules applied byte by byte to a string whose final byte carries in_last.
    task automatic model(input string s);
        int line, col, val, ncols, n;
        byte c;
        bit last, op, ends;
        line = 0; col = 0; val = -1; ncols = 0;
        exp_w.delete(); exp_i.delete();
        exp_done = 0; exp_err = 0; exp_sum = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            last = (i == s.len() - 1);
            if (exp_done || exp_err) continue;
            if (line < 4) begin
                n = col + ((val >= 0) ? 1 : 0);
                if (last) exp_err = 1;
                else if (c >= 48 && c <= 57) begin
                    val = ((val < 0) ? 0 : val) * 10 + (int'(c) - 48);
                    if (val > 65535) exp_err = 1;
                end else if (c == 8'h20 || c == 8'h0A) begin
                    if (val >= 0 && col >= MAXC) exp_err = 1;
                    else if (c == 8'h0A && n > 0 && line > 0 && n != ncols) exp_err = 1;
                    else begin
                        if (val >= 0) push_exp(line, col, val, i);
                        col = n; val = -1;
                        if (c == 8'h0A && n > 0) begin
                            if (line == 0) ncols = n;
                            line++; col = 0;
                        end
                    end
                end else if (c != 8'h0D) exp_err = 1;
            end else begin
                op   = (c == 8'h2A || c == 8'h2B);
                ends = (c == 8'h0A) || last;
                n    = col + (op ? 1 : 0);
                if (!(op || c == 8'h20 || c == 8'h0A || c == 8'h0D)) exp_err = 1;
                else if (op && col >= MAXC) exp_err = 1;
                else if (ends && n == 0 && last) exp_err = 1;
                else if (ends && n > 0 && n != ncols) exp_err = 1;
                else begin
                    if (op) push_exp(4, col, (c == 8'h2B) ? 1 : 0, i);
                    col = n;
                    if (ends && n > 0) exp_done = 1;
                end
            end
        end
        exp_ncols = ncols;
    endtask

    task automatic pulse_start();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        dut_w.delete(); dut_c.delete();
    endtask

    // Streams s with random valid gaps; in_last on the final byte when last is set.
    task automatic send(input string s, input bit last, input int gap);
        int i = 0;
        int guard = 0;
        while (i < s.len()) begin
            @(negedge clk); #1;
            in_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, gap) != 0);
            in_data  = s[i];
            in_last  = last && (i == s.len() - 1);
            if (in_valid && in_ready) begin
                byte_cyc[i] = cyc;
                i++;
            end
            guard++;
            if (guard > 20000) begin
                check("send_timeout", 64'(guard), 64'(0));
                break;
            end
        end
        @(negedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic run(input string tag, input string s, input int gap);
        int n;
        model(s);
        pulse_start();
        send(s, 1'b1, gap);
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_nwr"}, 64'(dut_w.size()), 64'(exp_w.size()));
        n = (dut_w.size() < exp_w.size()) ? dut_w.size() : exp_w.size();
        for (int k = 0; k < n; k++) begin
            check({tag, "_wr"}, 64'(dut_w[k]), 64'(exp_w[k]));
            check({tag, "_lat"}, 64'(dut_c[k]), 64'(byte_cyc[exp_i[k]] + 1));
        end
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_excl"}, 64'(done && error), 64'(0));
        if (exp_done) check({tag, "_ncols"}, 64'(num_cols), 64'(exp_ncols));
        if (exp_err) check({tag, "_drain_rdy"}, 64'(in_ready), 64'(1));
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_csum"}, checksum, exp_sum);
`else
        check({tag, "_csum"}, checksum, 64'(0));
`endif
    endtask

    function automatic string gen_sheet();
        string s = "";
        int nc = $urandom_range(1, 5);
        int v;
        byte pool[8] = '{8'h78, 8'h35, 8'h20, 8'h0A, 8'h2A, 8'h2B, 8'h37, 8'h0D};
        for (int l = 0; l < 4; l++) begin
            if ($urandom_range(0, 5) == 0) s = {s, "\n"};
            if ($urandom_range(0, 1) == 1) s = {s, " "};
            for (int c = 0; c < nc; c++) begin
                v = ($urandom_range(0, 5) == 0) ? $urandom_range(65530, 65536) : $urandom_range(0, 999);
                s = {s, $sformatf("%0d", v)};
                if (c < nc - 1 || $urandom_range(0, 1) == 1) s = {s, " "};
                if ($urandom_range(0, 2) == 0) s = {s, " "};
            end
            if ($urandom_range(0, 3) == 0) s = {s, "\r"};
            s = {s, "\n"};
        end
        for (int c = 0; c < nc; c++) begin
            s = {s, ($urandom_range(0, 1) == 1) ? "+" : "*"};
            if (c < nc - 1) s = {s, "  "};
        end
        if ($urandom_range(0, 1) == 1) s = {s, " \n"};
        if ($urandom_range(0, 2) == 0) s[$urandom_range(0, s.len() - 1)] = pool[$urandom_range(0, 7)];
        return s;
    endfunction

    string s29 = "123 328  51 64 \n 45 64  387 23 \n  6 98  215 314\n1 2 3 4\n*   +   *   +  \n";
    string s33 = "123 328  51 64 \n 45 64  387 23 \n  6 98  215 314\n1 2 3 4\n*   +   *   +";

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_ncols", 64'(num_cols), 64'(0));
        check("rst_csum", checksum, 64'(0));
        check("rst_wr_bus", 64'({wr_line, wr_col, wr_data}), 64'(0));
        rst = 1'b0;

        run("sample", s29, 0);
        check("sample_ncols4", 64'(num_cols), 64'(4));
        run("sample_gaps", s29, 3);
        run("last_on_plus", s33, 2);
        run("ovf_65536", "65536 1\n", 0);
        run("max_65535", "65535 2\n", 1);
        if (dut_w.size() > 0) check("max_data", 64'(dut_w[0][15:0]), 64'(16'hFFFF));
        else check("max_present", 64'(0), 64'(1));
        run("short_line1", "1 2 3 4\n5 6 7\n8 9 1 2\n3 4 5 6\n* + * +\n", 2);
        run("bad_x", "1 2\n3 x 4\n5 6\n7 8\n* +\n", 0);
        run("bad_op5", "1 2\n3 4\n5 6\n7 8\n* 5 +\n", 0);
        run("restart_after_err", s29, 1);

        // Abort mid-stream with rst, then restart from the top.
        pulse_start();
        send("123 328  51 64 \n 45 64  387 23 ", 1'b0, 0);
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_wr_en", 64'(wr_en), 64'(0));
        check("midrst_ready", 64'(in_ready), 64'(0));
        check("midrst_ncols", 64'(num_cols), 64'(0));
        rst = 1'b0;
        run("after_rst", s29, 2);

        for (int t = 0; t < 30; t++) begin
            run($sformatf("rnd%0d", t), gen_sheet(), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
